mix_round_sequencer: RTL and testbench

//  Multi-cycle controller for the 8x32-bit mixing datapath. Runs the 16 mixing stages
//  one stage per clock instead of all in one cycle. Accepts a 256-bit seed on a

---
 rtl/mix_seq_pkg.sv | 34 +++
 rtl/mix_stage_alu.sv | 32 +++
 rtl/mix_round_sequencer.sv | 119 +++++++++++
 tb/tb_mix_round_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mix_seq_pkg.sv
// Shared types and constants for the multi-cycle 8x32-bit mixing sequencer.
package mix_seq_pkg;

  localparam int unsigned NUM_STAGES = 16;
  localparam int unsigned NUM_WORDS  = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned STATE_W    = 2;
  localparam int unsigned STAGE_W    = 4;
  localparam int unsigned PASS_W     = 8;
  localparam int unsigned KIND_W     = 3;
  localparam int unsigned DATA_W     = NUM_WORDS * WORD_W;

  // FSM encoding: IDLE -> RUN -> DONE -> IDLE
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  typedef logic [KIND_W-1:0] stage_kind_t;

  // Word i sits at bits [32*i +: 32], matching the in_data/out_data packing.
  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] word_vec_t;

  // Element 0 is the rightmost entry of each concatenation.
  localparam word_vec_t MIX_A = {32'd19, 32'd17, 32'd13, 32'd11, 32'd7,  32'd5,  32'd3, 32'd2};
  localparam word_vec_t MIX_B = {32'd23, 32'd19, 32'd17, 32'd13, 32'd11, 32'd7,  32'd5, 32'd3};
  localparam word_vec_t MIX_C = {32'd87, 32'd35, 32'd13, 32'd5,  32'd3,  32'd3,  32'd3, 32'd2};
  localparam word_vec_t MIX_D = {32'd343, 32'd216, 32'd125, 32'd64, 32'd27, 32'd8, 32'd1, 32'd0};

  // Each stage kind runs for two consecutive stages.
  function automatic stage_kind_t stage_kind(input logic [STAGE_W-1:0] idx);
    return idx[STAGE_W-1:1];
  endfunction

endpackage

// File: rtl/mix_stage_alu.sv
// Combinational single-stage mixer: applies one stage kind to all eight words,
// updating them in order 0..7 so each word sees already-updated lower words.
module mix_stage_alu
  import mix_seq_pkg::*;
(
  input  logic [KIND_W-1:0] kind,
  input  logic [DATA_W-1:0] w,
  output logic [DATA_W-1:0] w_next_c
);

  word_vec_t v;

  // Chained in-order update; index arithmetic wraps mod 8 via 3-bit casts.
  always_comb begin
    v = word_vec_t'(w);
    for (int i = 0; i < int'(NUM_WORDS); i++) begin
      unique case (kind)
        3'd0: v[i] = v[i] + WORD_W'(i);
        3'd1: v[i] = v[i] + v[3'(i + 7)];
        3'd2: v[i] = v[i] + v[3'(i + 1)] - v[3'(i + 5)];
        3'd3: v[i] = v[i] ^ (v[3'(i + 3)] << 16);
        3'd4: v[i] = v[i] - (v[3'(i + 2)] >> 17) + (v[3'(i + 4)] >> 12);
        3'd5: v[i] = v[i] + v[3'(i + 7)] - v[3'(i + 6)];
        3'd6: v[i] = v[i] * MIX_A[i] + MIX_B[i];
        3'd7: v[i] = v[i] * MIX_C[i] + MIX_D[i];
        default: v[i] = v[i];
      endcase
    end
    w_next_c = DATA_W'(v);
  end

endmodule

// File: rtl/mix_round_sequencer.sv
// Multi-cycle mixing controller: accepts a 256-bit seed, applies one of 16
// stages per clock for PASSES full passes, then presents the mixed state.
// Optional build macro MIX_SEQ_CHECKSUM_EN adds a 32-bit XOR checksum port chk.
module mix_round_sequencer
  import mix_seq_pkg::*;
#(
  parameter int unsigned PASSES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                busy,
  output logic [STAGE_W-1:0]  stage_idx,
  output logic [PASS_W-1:0]   pass_cnt
`ifdef MIX_SEQ_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0]   chk
`endif
);

  if (PASSES < 1 || PASSES > 255) begin : g_bad_passes
    $error("mix_round_sequencer: PASSES must be in 1..255");
  end

  localparam logic [PASS_W-1:0]  LAST_PASS  = PASS_W'(PASSES - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  logic [STATE_W-1:0] state, state_d;
  logic [DATA_W-1:0]  w, w_d, alu_w_c;
  logic [STAGE_W-1:0] stage_d;
  logic [PASS_W-1:0]  pass_d;

  mix_stage_alu u_alu (
    .kind     (stage_kind(stage_idx)),
    .w        (w),
    .w_next_c (alu_w_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state, datapath and counter update.
  always_comb begin
    state_d = state;
    w_d     = w;
    stage_d = stage_idx;
    pass_d  = pass_cnt;
    unique case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          w_d     = in_data;
          stage_d = '0;
          pass_d  = '0;
        end
      end
      ST_RUN: begin
        w_d     = alu_w_c;
        stage_d = STAGE_W'(stage_idx + 4'd1);
        if (stage_idx == LAST_STAGE) begin
          pass_d = PASS_W'(pass_cnt + 8'd1);
          if (pass_cnt == LAST_PASS) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered datapath, counters and state-decoded handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      w         <= '0;
      stage_idx <= '0;
      pass_cnt  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      w         <= w_d;
      stage_idx <= stage_d;
      pass_cnt  <= pass_d;
      in_ready  <= (state_d == ST_IDLE);
      out_valid <= (state_d == ST_DONE);
      busy      <= (state_d == ST_RUN);
    end
  end

  assign out_data = w;

`ifdef MIX_SEQ_CHECKSUM_EN
  logic [WORD_W-1:0] chk_d;
  word_vec_t         w_d_vec;

  // XOR of the final words, folded from the next-state datapath.
  always_comb begin
    w_d_vec = word_vec_t'(w_d);
    chk_d   = '0;
    for (int i = 0; i < int'(NUM_WORDS); i++) chk_d = chk_d ^ w_d_vec[i];
  end

  // Checksum captured on the RUN -> DONE transition.
  always_ff @(posedge clk) begin
    if (rst)                                    chk <= '0;
    else if (state == ST_RUN && state_d == ST_DONE) chk <= chk_d;
  end
`endif

endmodule

// File: tb/tb_mix_round_sequencer.sv
// Self-checking bench for mix_round_sequencer: two instances (PASSES=1 and
// PASSES=3) share the clock and reset; sel routes stimulus to one of them.
module tb_mix_round_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, out_ready, sel;
  logic [255:0] in_data;

  logic         ir0, ov0, bz0, ir1, ov1, bz1;
  logic [255:0] od0, od1;
  logic [3:0]   si0, si1;
  logic [7:0]   pc0, pc1;
  logic [31:0]  ck0, ck1;

  logic iv0, iv1, or0, or1;
  assign iv0 = in_valid  & ~sel;
  assign iv1 = in_valid  &  sel;
  assign or0 = out_ready & ~sel;
  assign or1 = out_ready &  sel;

  logic         d_in_ready, d_out_valid, d_busy;
  logic [255:0] d_out_data;
  logic [3:0]   d_stage;
  logic [7:0]   d_pass;
  logic [31:0]  d_chk;
  assign d_in_ready  = sel ? ir1 : ir0;
  assign d_out_valid = sel ? ov1 : ov0;
  assign d_busy      = sel ? bz1 : bz0;
  assign d_out_data  = sel ? od1 : od0;
  assign d_stage     = sel ? si1 : si0;
  assign d_pass      = sel ? pc1 : pc0;
  assign d_chk       = sel ? ck1 : ck0;

`ifndef MIX_SEQ_CHECKSUM_EN
  assign ck0 = '0;
  assign ck1 = '0;
`endif

  mix_round_sequencer #(.PASSES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .busy(bz0),
    .stage_idx(si0), .pass_cnt(pc0)
`ifdef MIX_SEQ_CHECKSUM_EN
    , .chk(ck0)
`endif
  );

  mix_round_sequencer #(.PASSES(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .busy(bz1),
    .stage_idx(si1), .pass_cnt(pc1)
`ifdef MIX_SEQ_CHECKSUM_EN
    , .chk(ck1)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference: passes x 16 stages, words updated in place in index order.
  function automatic logic [255:0] mix_model(input logic [255:0] seed, input int passes);
    logic [31:0] w  [8];
    logic [31:0] ka [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
    logic [31:0] kb [8] = '{3, 5, 7, 11, 13, 17, 19, 23};
    logic [31:0] kc [8] = '{2, 3, 3, 3, 5, 13, 35, 87};
    logic [31:0] kd [8] = '{0, 1, 8, 27, 64, 125, 216, 343};
    logic [255:0] r;
    for (int i = 0; i < 8; i++) w[i] = seed[32*i +: 32];
    for (int p = 0; p < passes; p++)
      for (int s = 0; s < 16; s++)
        for (int i = 0; i < 8; i++)
          case (s / 2)
            0: w[i] = w[i] + 32'(i);
            1: w[i] = w[i] + w[(i + 7) % 8];
            2: w[i] = w[i] + w[(i + 1) % 8] - w[(i + 5) % 8];
            3: w[i] = w[i] ^ (w[(i + 3) % 8] << 16);
            4: w[i] = w[i] - (w[(i + 2) % 8] >> 17) + (w[(i + 4) % 8] >> 12);
            5: w[i] = w[i] + w[(i + 7) % 8] - w[(i + 6) % 8];
            6: w[i] = w[i] * ka[i] + kb[i];
            default: w[i] = w[i] * kc[i] + kd[i];
          endcase
    for (int i = 0; i < 8; i++) r[32*i +: 32] = w[i];
    return r;
  endfunction

  function automatic logic [255:0] rand_seed();
    logic [255:0] s;
    for (int i = 0; i < 8; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  function automatic logic [31:0] xor_words(input logic [255:0] v);
    logic [31:0] x = '0;
    for (int i = 0; i < 8; i++) x = x ^ v[32*i +: 32];
    return x;
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Offer a seed while in IDLE; returns one cycle after the accept edge.
  task automatic start_job(input logic [255:0] seed);
    in_data  = seed;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Follow a running job to out_valid, checking counters, latency and result.
  task automatic wait_job(input logic [255:0] exp, input int passes, input string tag);
    int cyc = 0;
    int es  = 0;
    int ep  = 0;
    while (!d_out_valid && cyc < 16 * passes + 20) begin
      tests++;
      if (d_stage !== 4'(es) || d_pass !== 8'(ep) || d_busy !== 1'b1 || d_in_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s_run cyc=%0d: stage=%0d pass=%0d busy=%b in_ready=%b, expected stage=%0d pass=%0d busy=1 in_ready=0",
                 tag, cyc, d_stage, d_pass, d_busy, d_in_ready, es, ep);
      end
      @(posedge clk); #1;
      cyc++;
      es++;
      if (es == 16) begin es = 0; ep++; end
    end
    tests++;
    if (cyc != 16 * passes) begin
      fails++;
      $display("FAIL %s_latency: got %0d clocks, expected %0d", tag, cyc, 16 * passes);
    end
    tests++;
    if (d_out_data !== exp) begin
      fails++;
      $display("FAIL %s_data: got %h expected %h", tag, d_out_data, exp);
    end
    tests++;
    if (d_busy !== 1'b0 || d_in_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s_done_flags: busy=%b in_ready=%b, expected 0 0", tag, d_busy, d_in_ready);
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_consume: out_valid=%b in_ready=%b, expected 0 1", tag, d_out_valid, d_in_ready);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      tests++;
      if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0 || d_busy !== 1'b0 ||
          d_stage !== 4'd0 || d_pass !== 8'd0 || d_out_data !== 256'd0) begin
        fails++;
        $display("FAIL reset_values sel=%0d: in_ready=%b out_valid=%b busy=%b stage=%0d pass=%0d data=%h",
                 s, d_in_ready, d_out_valid, d_busy, d_stage, d_pass, d_out_data);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_golden();
    logic [255:0] seed;
    sel = 1'b0;
    for (int i = 0; i < 8; i++) seed[32*i +: 32] = 32'(i);
    start_job(seed);
    wait_job(mix_model(seed, 1), 1, "golden");
    consume("golden");
  endtask

  task automatic test_multipass();
    logic [255:0] seed;
    sel = 1'b1;
    for (int n = 0; n < 2; n++) begin
      seed = rand_seed();
      start_job(seed);
      wait_job(mix_model(seed, 3), 3, "multipass");
      consume("multipass");
    end
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [255:0] s0, s1, exp0;
    sel  = 1'b0;
    s0   = rand_seed();
    s1   = rand_seed();
    exp0 = mix_model(s0, 1);
    start_job(s0);
    wait_job(exp0, 1, "bp_first");
    in_data  = s1;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      tests++;
      if (d_out_valid !== 1'b1 || d_in_ready !== 1'b0 || d_out_data !== exp0) begin
        fails++;
        $display("FAIL bp_hold cyc=%0d: out_valid=%b in_ready=%b data=%h expected 1 0 %h",
                 c, d_out_valid, d_in_ready, d_out_data, exp0);
      end
    end
    consume("bp_release");
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (d_busy !== 1'b1 || d_stage !== 4'd0) begin
      fails++;
      $display("FAIL bp_held_accept: busy=%b stage=%0d, expected 1 0", d_busy, d_stage);
    end
    wait_job(mix_model(s1, 1), 1, "bp_second");
    consume("bp_second");
  endtask

  task automatic test_reset_midrun();
    bit seen = 1'b0;
    sel = 1'b0;
    start_job(rand_seed());
    repeat (7) begin @(posedge clk); #1; end
    tests++;
    if (d_stage !== 4'd7) begin
      fails++;
      $display("FAIL midrun_stage: got %0d expected 7", d_stage);
    end
    pulse_reset();
    tests++;
    if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0 || d_busy !== 1'b0 ||
        d_stage !== 4'd0 || d_out_data !== 256'd0) begin
      fails++;
      $display("FAIL midrun_reset: in_ready=%b out_valid=%b busy=%b stage=%0d data=%h",
               d_in_ready, d_out_valid, d_busy, d_stage, d_out_data);
    end
    out_ready = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (d_out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL midrun_stale: out_valid=1 seen after reset, expected never");
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] s0, s1;
    logic [255:0] exp [2];
    int  sent = 0;
    int  got  = 0;
    int  cyc  = 0;
    bit  acc;
    sel    = 1'b1;
    s0     = rand_seed();
    s1     = rand_seed();
    exp[0] = mix_model(s0, 3);
    exp[1] = mix_model(s1, 3);
    out_ready = 1'b1;
    in_data   = s0;
    in_valid  = 1'b1;
    while (got < 2 && cyc < 250) begin
      tests++;
      if (d_out_valid && d_in_ready) begin
        fails++;
        $display("FAIL b2b_overlap cyc=%0d: out_valid=1 in_ready=1, expected not both", cyc);
      end
      if (d_out_valid) begin
        tests++;
        if (d_out_data !== exp[got]) begin
          fails++;
          $display("FAIL b2b_data%0d: got %h expected %h", got, d_out_data, exp[got]);
        end
        got++;
      end
      acc = d_in_ready && in_valid;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        if (sent == 1) in_data = s1;
        else           in_valid = 1'b0;
      end
    end
    tests++;
    if (got != 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d results expected 2", got);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel       = 1'b0;
  endtask

`ifdef MIX_SEQ_CHECKSUM_EN
  task automatic test_checksum();
    logic [255:0] exp;
    sel = 1'b0;
    exp = mix_model(256'd0, 1);
    start_job(256'd0);
    wait_job(exp, 1, "chk");
    tests++;
    if (d_chk !== xor_words(exp)) begin
      fails++;
      $display("FAIL chk_value: got %h expected %h", d_chk, xor_words(exp));
    end
    pulse_reset();
    tests++;
    if (d_chk !== 32'd0) begin
      fails++;
      $display("FAIL chk_reset: got %h expected 0", d_chk);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel       = 1'b0;
    in_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_golden();
    test_multipass();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
`ifdef MIX_SEQ_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
